// File: rtl/skew_feed_buffer_if.sv
// Host-side bundle for the skew feed buffer: write port, stream control,
// skewed lane outputs and the combinational debug read port.
interface skew_feed_buffer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int LINES      = 4,
   parameter int DEPTH      = 4
);
   localparam int LW = $clog2(LINES);
   localparam int EW = $clog2(DEPTH);

   logic                        write_enable;
   logic [LW-1:0]               write_line;
   logic [EW-1:0]               write_elem;
   logic [DATA_WIDTH-1:0]       data_in;
   logic                        start;
   logic                        busy;
   logic                        done;
   logic                        write_err;
   logic [LINES-1:0]            lane_valid;
   logic [DATA_WIDTH*LINES-1:0] data_out;
   logic [LW-1:0]               dbg_line;
   logic [EW-1:0]               dbg_elem;
   logic [DATA_WIDTH-1:0]       dbg_data;

   // Host side: drives writes, start and debug address.
   modport master (
      output write_enable, write_line, write_elem, data_in, start, dbg_line, dbg_elem,
      input  busy, done, write_err, lane_valid, data_out, dbg_data
   );

   // Buffer side.
   modport slave (
      input  write_enable, write_line, write_elem, data_in, start, dbg_line, dbg_elem,
      output busy, done, write_err, lane_valid, data_out, dbg_data
   );
endinterface

// File: rtl/skew_feed_buffer.sv
// LINES x DEPTH operand buffer feeding the systolic array edge. A start
// request streams every line in parallel with line i delayed i beats, so the
// array receives diagonally staggered operands. Writes are refused while a
// stream is in flight so the streamed data is always a consistent snapshot.
module skew_feed_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int LINES      = 4,
   parameter int DEPTH      = 4
) (
   input logic             clk,
   input logic             rst_n,
   skew_feed_buffer_if.slave bus
);
   localparam int LW = $clog2(LINES);
   localparam int EW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + LINES);
   localparam logic [CW-1:0] LAST_BEAT = CW'(DEPTH + LINES - 2);

   typedef enum logic {
      IDLE,
      STREAM
   } state_t;

   state_t                      state;
   logic [CW-1:0]               cnt;
   logic                        busy_q;
   logic                        done_q;
   logic                        write_err_q;
   logic [LINES-1:0]            lane_valid_q;
   logic [DATA_WIDTH*LINES-1:0] data_out_q;

   logic [DATA_WIDTH-1:0]       mem [LINES][DEPTH];
   logic [LINES-1:0]            beat_valid;
   logic [DATA_WIDTH-1:0]       beat_data [LINES];
   int                          offset;

   // Storage and write port; writes arriving during a stream are dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int l = 0; l < LINES; l++) begin
            for (int e = 0; e < DEPTH; e++) begin
               mem[l][e] <= '0;
            end
         end
         write_err_q <= 1'b0;
      end else begin
         write_err_q <= bus.write_enable && busy_q;
         if (bus.write_enable && !busy_q) begin
            mem[bus.write_line][bus.write_elem] <= bus.data_in;
         end
      end
   end

   // Select the element each lane presents on the current beat: lane i shows element cnt-i.
   always_comb begin
      offset = 0;
      for (int i = 0; i < LINES; i++) begin
         offset        = int'(cnt) - i;
         beat_valid[i] = 1'b0;
         beat_data[i]  = '0;
         if (offset >= 0 && offset < DEPTH) begin
            beat_valid[i] = 1'b1;
            beat_data[i]  = mem[i][offset[EW-1:0]];
         end
      end
   end

   // Stream sequencer: one beat per cycle, done on the final diagonal beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         lane_valid_q <= '0;
         data_out_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               lane_valid_q <= '0;
               data_out_q   <= '0;
               if (bus.start) begin
                  state  <= STREAM;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            STREAM: begin
               lane_valid_q <= beat_valid;
               for (int i = 0; i < LINES; i++) begin
                  data_out_q[DATA_WIDTH*i +: DATA_WIDTH] <= beat_data[i];
               end
               if (cnt == LAST_BEAT) begin
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
                  cnt    <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.write_err  = write_err_q;
   assign bus.lane_valid = lane_valid_q;
   assign bus.data_out   = data_out_q;
   assign bus.dbg_data   = mem[bus.dbg_line][bus.dbg_elem];
endmodule

// File: tb/tb_skew_feed_buffer.sv
// Self-checking bench for skew_feed_buffer: a 4x4 instance exercised with
// directed and randomized streams, plus a 2x8 instance for the shape change.
module tb_skew_feed_buffer;
   localparam int DW  = 8;
   localparam int L   = 4;
   localparam int D   = 4;
   localparam int LW  = $clog2(L);
   localparam int EW  = $clog2(D);
   localparam int SL  = 2;
   localparam int SD  = 8;
   localparam int SLW = $clog2(SL);
   localparam int SEW = $clog2(SD);
   localparam int LAST  = D + L - 2;
   localparam int SLAST = SD + SL - 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   skew_feed_buffer_if #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) bus ();
   skew_feed_buffer_if #(.DATA_WIDTH(DW), .LINES(SL), .DEPTH(SD)) sbus ();

   skew_feed_buffer #(.DATA_WIDTH(DW), .LINES(L), .DEPTH(D)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   skew_feed_buffer #(.DATA_WIDTH(DW), .LINES(SL), .DEPTH(SD)) sdut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (sbus.slave)
   );

   int check_count = 0;
   int pass_count  = 0;

   logic [DW-1:0] model_mem [L][D];
   logic [DW-1:0] small_mem [SL][SD];

   // Single comparison point for the whole bench.
   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
      end
   endtask

   // Lane i carries element k-i on beat k whenever that element exists.
   function automatic logic [L-1:0] exp_valid(input int k);
      logic [L-1:0] v = '0;
      for (int i = 0; i < L; i++) begin
         if (k - i >= 0 && k - i < D) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [DW*L-1:0] exp_data(input int k);
      logic [DW*L-1:0] d = '0;
      for (int i = 0; i < L; i++) begin
         if (k - i >= 0 && k - i < D) d[DW*i +: DW] = model_mem[i][k-i];
      end
      return d;
   endfunction

   function automatic logic [SL-1:0] s_exp_valid(input int k);
      logic [SL-1:0] v = '0;
      for (int i = 0; i < SL; i++) begin
         if (k - i >= 0 && k - i < SD) v[i] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [DW*SL-1:0] s_exp_data(input int k);
      logic [DW*SL-1:0] d = '0;
      for (int i = 0; i < SL; i++) begin
         if (k - i >= 0 && k - i < SD) d[DW*i +: DW] = small_mem[i][k-i];
      end
      return d;
   endfunction

   // Write one cell of the 4x4 buffer while idle.
   task automatic write_cell(input int l, input int e, input logic [DW-1:0] v);
      @(negedge clk);
      bus.write_enable = 1'b1;
      bus.write_line   = LW'(l);
      bus.write_elem   = EW'(e);
      bus.data_in      = v;
      model_mem[l][e]  = v;
      @(negedge clk);
      bus.write_enable = 1'b0;
   endtask

   // Combinational debug readback against the model.
   task automatic check_dbg(input int l, input int e);
      bus.dbg_line = LW'(l);
      bus.dbg_elem = EW'(e);
      #1;
      check_output($sformatf("dbg[%0d][%0d]", l, e), 64'(bus.dbg_data), 64'(model_mem[l][e]));
   endtask

   // Full stream with optional same-edge write, mid-stream write and mid-stream restart.
   task automatic apply_stimulus(input bit pre_write, input int write_beat, input int wl, input int we,
                                 input logic [DW-1:0] wd, input int restart_beat);
      @(negedge clk);
      bus.start = 1'b1;
      if (pre_write) begin
         bus.write_enable = 1'b1;
         bus.write_line   = LW'(wl);
         bus.write_elem   = EW'(we);
         bus.data_in      = wd;
         model_mem[wl][we] = wd;
      end
      @(negedge clk);
      bus.start        = 1'b0;
      bus.write_enable = 1'b0;
      check_output("busy_after_start", 64'(bus.busy), 64'(1));
      for (int k = 0; k <= LAST; k++) begin
         @(negedge clk);
         bus.start        = 1'b0;
         bus.write_enable = 1'b0;
         check_output($sformatf("valid_b%0d", k), 64'(bus.lane_valid), 64'(exp_valid(k)));
         check_output($sformatf("data_b%0d", k), 64'(bus.data_out), 64'(exp_data(k)));
         check_output($sformatf("done_b%0d", k), 64'(bus.done), 64'(k == LAST));
         check_output($sformatf("busy_b%0d", k), 64'(bus.busy), 64'(k != LAST));
         check_output($sformatf("write_err_b%0d", k), 64'(bus.write_err),
                      64'(write_beat >= 0 && k == write_beat + 1));
         check_dbg(int'($urandom_range(0, L - 1)), int'($urandom_range(0, D - 1)));
         if (k == write_beat) begin
            bus.write_enable = 1'b1;
            bus.write_line   = LW'(wl);
            bus.write_elem   = EW'(we);
            bus.data_in      = wd;
         end
         if (k == restart_beat) bus.start = 1'b1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      check_output("busy_end", 64'(bus.busy), 64'(0));
      check_output("done_end", 64'(bus.done), 64'(0));
      check_output("valid_end", 64'(bus.lane_valid), 64'(0));
      check_output("data_end", 64'(bus.data_out), 64'(0));
      check_output("write_err_end", 64'(bus.write_err), 64'(0));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.write_enable  = 1'b0;
      bus.write_line    = '0;
      bus.write_elem    = '0;
      bus.data_in       = '0;
      bus.start         = 1'b0;
      bus.dbg_line      = '0;
      bus.dbg_elem      = '0;
      sbus.write_enable = 1'b0;
      sbus.write_line   = '0;
      sbus.write_elem   = '0;
      sbus.data_in      = '0;
      sbus.start        = 1'b0;
      sbus.dbg_line     = '0;
      sbus.dbg_elem     = '0;
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) model_mem[l][e] = '0;
      for (int l = 0; l < SL; l++) for (int e = 0; e < SD; e++) small_mem[l][e] = '0;

      // Reset state and cleared memory.
      repeat (2) @(negedge clk);
      check_output("reset_busy", 64'(bus.busy), 64'(0));
      check_output("reset_valid", 64'(bus.lane_valid), 64'(0));
      check_output("reset_data", 64'(bus.data_out), 64'(0));
      check_output("reset_done", 64'(bus.done), 64'(0));
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) check_dbg(l, e);
      @(negedge clk);
      rst_n = 1'b1;

      // Pattern 0x10*i+e, then a clean stream.
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) write_cell(l, e, DW'(16 * l + e));
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) check_dbg(l, e);
      apply_stimulus(1'b0, -1, 0, 0, '0, -1);

      // Dropped write during a stream, then an identical repeat stream.
      apply_stimulus(1'b0, 2, 0, 0, 8'hFF, -1);
      check_dbg(0, 0);
      apply_stimulus(1'b0, -1, 0, 0, '0, -1);

      // Start re-asserted mid-stream is ignored.
      apply_stimulus(1'b0, -1, 0, 0, '0, 2);

      // Asynchronous reset during beat 3.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      check_output("abort_pre_valid", 64'(bus.lane_valid), 64'(exp_valid(3)));
      #2;
      rst_n = 1'b0;
      #1;
      check_output("abort_valid", 64'(bus.lane_valid), 64'(0));
      check_output("abort_data", 64'(bus.data_out), 64'(0));
      check_output("abort_busy", 64'(bus.busy), 64'(0));
      check_output("abort_done", 64'(bus.done), 64'(0));
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) model_mem[l][e] = '0;
      for (int l = 0; l < L; l++) for (int e = 0; e < D; e++) check_dbg(l, e);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < D + L; c++) begin
         @(negedge clk);
         check_output($sformatf("abort_nodone_%0d", c), 64'(bus.done), 64'(0));
         check_output($sformatf("abort_idle_%0d", c), 64'(bus.busy), 64'(0));
      end
      apply_stimulus(1'b0, -1, 0, 0, '0, -1);

      // Same-edge start and write reaches the stream.
      apply_stimulus(1'b1, -1, 2, 0, 8'hAB, -1);

      // Randomized contents, dropped writes and restarts.
      for (int it = 0; it < 12; it++) begin
         for (int w = 0; w < 6; w++) begin
            write_cell(int'($urandom_range(0, L - 1)), int'($urandom_range(0, D - 1)), DW'($urandom));
         end
         apply_stimulus(1'($urandom_range(0, 1)),
                        int'($urandom_range(0, LAST)) - 1,
                        int'($urandom_range(0, L - 1)), int'($urandom_range(0, D - 1)), DW'($urandom),
                        int'($urandom_range(0, LAST)) - 1);
      end

      // 2x8 instance: pattern, then a 9-beat stream.
      for (int l = 0; l < SL; l++) begin
         for (int e = 0; e < SD; e++) begin
            @(negedge clk);
            sbus.write_enable = 1'b1;
            sbus.write_line   = SLW'(l);
            sbus.write_elem   = SEW'(e);
            sbus.data_in      = DW'(16 * l + e);
            small_mem[l][e]   = DW'(16 * l + e);
         end
      end
      @(negedge clk);
      sbus.write_enable = 1'b0;
      sbus.start        = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      check_output("s_busy_start", 64'(sbus.busy), 64'(1));
      for (int k = 0; k <= SLAST; k++) begin
         @(negedge clk);
         check_output($sformatf("s_valid_b%0d", k), 64'(sbus.lane_valid), 64'(s_exp_valid(k)));
         check_output($sformatf("s_data_b%0d", k), 64'(sbus.data_out), 64'(s_exp_data(k)));
         check_output($sformatf("s_done_b%0d", k), 64'(sbus.done), 64'(k == SLAST));
      end
      @(negedge clk);
      check_output("s_busy_end", 64'(sbus.busy), 64'(0));
      check_output("s_valid_end", 64'(sbus.lane_valid), 64'(0));

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end
endmodule
